// File: rtl/dth_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dth_responder
// Description : DHT11/DHT22-style single-wire sensor emulator (bus slave).
//               Optional DTH_AUTO_CSUM_EN replaces the checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module dth_responder #(
    parameter int CLK_F         = 100000000,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int ACK_US        = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 26,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] dth_data,
    inout  wire         DTH,
    output logic        busy,
    output logic        frame_done,
    output logic [5:0]  bit_idx
);

    localparam int              c_div       = CLK_F / 1000000;
    localparam int              c_pw        = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_pw-1:0] c_div_m1    = c_pw'(c_div - 1);
    localparam logic [15:0]     c_start_min = 16'(START_MIN_US);
    localparam logic [15:0]     c_resp_m1   = 16'(RESP_DELAY_US - 1);
    localparam logic [15:0]     c_ack_m1    = 16'(ACK_US - 1);
    localparam logic [15:0]     c_blow_m1   = 16'(BIT_LOW_US - 1);
    localparam logic [15:0]     c_b0_m1     = 16'(BIT0_HIGH_US - 1);
    localparam logic [15:0]     c_b1_m1     = 16'(BIT1_HIGH_US - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOST_LOW = 3'd1,
        S_HOST_REL = 3'd2,
        S_ACK_LOW  = 3'd3,
        S_ACK_HIGH = 3'd4,
        S_BIT_LOW  = 3'd5,
        S_BIT_HIGH = 3'd6,
        S_END_LOW  = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sync;
    logic [c_pw-1:0] r_presc;
    logic [15:0]     r_timer;
    logic [39:0]     r_shift;
    logic [5:0]      r_bit_idx;
    logic            r_frame_done;
    logic            w_dth_s;
    logic            w_tick;
    logic            w_drive_low;
    logic [15:0]     w_high_m1;
    logic [39:0]     w_latch;

    assign w_dth_s   = r_sync[1];
    assign w_tick    = (r_presc == c_div_m1);
    assign w_high_m1 = r_shift[39] ? c_b1_m1 : c_b0_m1;

`ifdef DTH_AUTO_CSUM_EN
    logic [7:0] w_csum;
    assign w_csum  = dth_data[39:32] + dth_data[31:24] + dth_data[23:16] + dth_data[15:8];
    assign w_latch = {dth_data[39:8], w_csum};
`else
    assign w_latch = dth_data;
`endif

    // Bus drive depends on state only, so an async reset frees the line at once.
    assign w_drive_low = (r_state == S_ACK_LOW) || (r_state == S_BIT_LOW) ||
                         (r_state == S_END_LOW);
    assign DTH         = w_drive_low ? 1'b0 : 1'bz;
    assign busy        = (r_state != S_IDLE) && (r_state != S_HOST_LOW);
    assign frame_done  = r_frame_done;
    assign bit_idx     = r_bit_idx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_dth_s) w_next = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                if (w_dth_s) w_next = (r_timer >= c_start_min) ? S_HOST_REL : S_IDLE;
            end
            S_HOST_REL: begin
                if (w_tick && (r_timer == c_resp_m1)) w_next = S_ACK_LOW;
            end
            S_ACK_LOW: begin
                if (w_tick && (r_timer == c_ack_m1)) w_next = S_ACK_HIGH;
            end
            S_ACK_HIGH: begin
                if (w_tick && (r_timer == c_ack_m1)) w_next = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                if (w_tick && (r_timer == c_blow_m1)) w_next = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (w_tick && (r_timer == w_high_m1))
                    w_next = (r_bit_idx == 6'd0) ? S_END_LOW : S_BIT_LOW;
            end
            S_END_LOW: begin
                if (w_tick && (r_timer == c_blow_m1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sync       <= 2'b11;
            r_presc      <= '0;
            r_timer      <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_sync       <= {r_sync[0], DTH};
            r_frame_done <= (r_state == S_END_LOW) && (w_next == S_IDLE);

            // Every state entry restarts the µs base so phases are exact multiples.
            if (w_next != r_state) begin
                r_presc <= '0;
                r_timer <= '0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
                if (w_tick && (r_timer != 16'hFFFF)) r_timer <= r_timer + 16'd1;
            end

            if ((r_state == S_HOST_LOW) && (w_next == S_HOST_REL)) r_shift <= w_latch;

            if ((r_state == S_ACK_HIGH) && (w_next == S_BIT_LOW)) begin
                r_bit_idx <= 6'd39;
            end else if ((r_state == S_BIT_HIGH) && (w_next != S_BIT_HIGH)) begin
                r_shift <= {r_shift[38:0], 1'b0};
                if (r_bit_idx != 6'd0) r_bit_idx <= r_bit_idx - 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dth_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dth_responder
// Description : Self-checking bench for dth_responder (host side + bus decoder).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dth_responder;

    localparam int CLK_F = 2000000;
    localparam int DIV   = CLK_F / 1000000;
    localparam int START = 1000;
    localparam int RESP  = 30;
    localparam int ACK   = 80;
    localparam int BL    = 50;
    localparam int B0    = 26;
    localparam int B1    = 70;

`ifdef DTH_AUTO_CSUM_EN
    localparam logic [39:0] c_csum_exp = 40'h1234567814;
`else
    localparam logic [39:0] c_csum_exp = 40'h12345678FF;
`endif

    typedef struct {
        logic [39:0] data;
        int          low_us;
        bit          accept;
        logic [39:0] exp_word;
    } vec_t;

    typedef struct {
        logic lvl;
        int   clocks;
    } seg_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] dth_data;
    logic        host_low;
    wire         dth_bus;
    logic        busy;
    logic        frame_done;
    logic [5:0]  bit_idx;

    logic        cur;
    logic [5:0]  cur_idx;
    logic        cur_busy;
    logic        cur_fd;
    int          n_checks = 0;
    int          n_errors = 0;

    pullup (dth_bus);
    assign dth_bus = host_low ? 1'b0 : 1'bz;

    dth_responder #(
        .CLK_F         (CLK_F),
        .START_MIN_US  (START),
        .RESP_DELAY_US (RESP),
        .ACK_US        (ACK),
        .BIT_LOW_US    (BL),
        .BIT0_HIGH_US  (B0),
        .BIT1_HIGH_US  (B1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .dth_data   (dth_data),
        .DTH        (dth_bus),
        .busy       (busy),
        .frame_done (frame_done),
        .bit_idx    (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
        cur      = dth_bus;
        cur_idx  = bit_idx;
        cur_busy = busy;
        cur_fd   = frame_done;
    endtask

    function automatic logic [39:0] model_word(input logic [39:0] d);
`ifdef DTH_AUTO_CSUM_EN
        int s;
        s = (int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8])) % 256;
        return {d[39:8], s[7:0]};
`else
        return d;
`endif
    endfunction

    function automatic logic [39:0] rand40();
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom();
        b = $urandom();
        return {a, b[7:0]};
    endfunction

    task automatic host_pulse(input int low_us, output int busy_cnt);
        busy_cnt = 0;
        @(posedge clk);
        #1;
        host_low = 1'b1;
        repeat (low_us * DIV) begin
            sample();
            if (cur_busy) busy_cnt++;
        end
        host_low = 1'b0;
    endtask

    // Expected waveform as a list of (level, clocks); the first high includes
    // the 2-clock input synchronizer latency seen from the host release.
    task automatic run_frame(input logic [39:0] data, input int low_us,
                             input logic [39:0] swap, input bit do_swap,
                             input logic [39:0] exp_word);
        seg_t        q[$];
        logic [39:0] w;
        logic [39:0] dec;
        int          n;
        int          busy_low;
        w = model_word(data);
        q.push_back('{1'b1, RESP * DIV + 2});
        q.push_back('{1'b0, ACK * DIV});
        q.push_back('{1'b1, ACK * DIV});
        for (int i = 39; i >= 0; i--) begin
            q.push_back('{1'b0, BL * DIV});
            q.push_back('{1'b1, (w[i] ? B1 : B0) * DIV});
        end
        q.push_back('{1'b0, BL * DIV});
        dth_data = data;
        dec      = '0;
        host_pulse(low_us, busy_low);
        check("busy_during_host_low", busy_low, 0);
        sample();
        for (int k = 0; k < q.size(); k++) begin
            if (k == 1) check("busy_in_frame", cur_busy, 1);
            if (k >= 3 && k < 83 && (k % 2) == 1) check("bit_idx", cur_idx, 39 - (k - 3) / 2);
            n = 0;
            while (cur === q[k].lvl && n < q[k].clocks + 50) begin
                n++;
                sample();
            end
            check($sformatf("seg%0d_len", k), n, q[k].clocks);
            if (k >= 4 && k < 83 && (k % 2) == 0) dec[39 - (k - 4) / 2] = (n > (B0 + B1) * DIV / 2);
            if (k == 1 && do_swap) dth_data = swap;
        end
        check("decoded_word", dec, exp_word);
        check("frame_done_pulse", cur_fd, 1);
        check("busy_clear", cur_busy, 0);
        check("bus_released", cur, 1);
        sample();
        check("frame_done_single", cur_fd, 0);
    endtask

    task automatic run_reject(input logic [39:0] data, input int low_us);
        int busy_cnt;
        int bad;
        dth_data = data;
        host_pulse(low_us, busy_cnt);
        bad = 0;
        repeat (200 * DIV) begin
            sample();
            if (cur_busy || cur_fd || !cur) bad++;
        end
        check("reject_busy_low", busy_cnt, 0);
        check("reject_quiet", bad, 0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[4];
        logic [39:0] d;
        bit          found;
        int          bad;
        int          bl;

        vecs[0] = '{40'h3C00190055, 1200, 1'b1, 40'h3C00190055};
        vecs[1] = '{40'h12345678FF, 1010, 1'b1, c_csum_exp};
        vecs[2] = '{40'hA5A5A5A5A5, 500,  1'b0, 40'h0};
        vecs[3] = '{40'h5A5A5A5A5A, 990,  1'b0, 40'h0};

        rst      = 1'b1;
        host_low = 1'b0;
        dth_data = '0;
        #1;
        check("reset_bus", dth_bus, 1);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_bit_idx", bit_idx, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) sample();

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].accept) run_frame(vecs[v].data, vecs[v].low_us, '0, 1'b0, vecs[v].exp_word);
            else                run_reject(vecs[v].data, vecs[v].low_us);
        end

        // Reset while bit 20 is in its low preamble.
        dth_data = rand40();
        host_pulse(1050, bl);
        found = 1'b0;
        for (int t = 0; t < 20000 && !found; t++) begin
            sample();
            if (!cur && cur_idx == 6'd20 && cur_busy) found = 1'b1;
        end
        check("reached_bit20", found, 1);
        rst = 1'b1;
        #1;
        check("midrst_bus", dth_bus, 1);
        check("midrst_busy", busy, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_bit_idx", bit_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            sample();
            if (cur_fd || cur_busy || !cur) bad++;
        end
        check("after_reset_quiet", bad, 0);
        d = rand40();
        run_frame(d, $urandom_range(1010, 1100), '0, 1'b0, model_word(d));

        // Data swapped during ACK high must not alter the frame in flight.
        run_frame(40'hFFFFFFFFFF, 1050, 40'h0, 1'b1, model_word(40'hFFFFFFFFFF));

        // Back-to-back frames, second start 10 µs after frame_done.
        d = rand40();
        run_frame(d, $urandom_range(1010, 1100), '0, 1'b0, model_word(d));
        repeat (10 * DIV - 2) sample();
        d = rand40();
        run_frame(d, $urandom_range(1010, 1100), '0, 1'b0, model_word(d));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
